// File: rtl/sfifo_pkg.sv
// Shared constants for the synchronous FIFO and its streaming reader.
package sfifo_pkg;

    localparam int unsigned FIFO_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_BITS  = 4;

    // Reader control states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sfifo_reader_if.sv
// Reader-side bus: sfifo read port plus the valid/ready output stream.
interface sfifo_reader_if #(
    parameter int unsigned WIDTH = sfifo_pkg::FIFO_WIDTH
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_read_n;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    // The reader drives the read strobe and the output stream
    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_n,
        output m_valid,
        output m_data,
        input  m_ready
    );

    // FIFO and downstream consumer side
    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read_n,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/sfifo.sv
// Synchronous FIFO with active-low strobes and registered read data.
module sfifo
    import sfifo_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_n_i,
    input  logic                  read_n_i,
    input  logic [FIFO_WIDTH-1:0] data_i,
    output logic [FIFO_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [FIFO_BITS:0]    count_o
);
    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_BITS-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_BITS:0]    count_q, count_d;
    logic [FIFO_WIDTH-1:0] rdata_q;
    logic                  do_wr, do_rd;

    // Strobes are qualified so the FIFO never over- or underflows
    always_comb begin
        full_o  = (count_q == (FIFO_BITS+1)'(FIFO_DEPTH));
        empty_o = (count_q == '0);
        do_wr   = !write_n_i && !full_o;
        do_rd   = !read_n_i && !empty_o;
        count_d = count_q + (FIFO_BITS+1)'(do_wr) - (FIFO_BITS+1)'(do_rd);
    end

    // Pointers, occupancy and registered read data
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rdata_q  <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = rdata_q;
    assign count_o = count_q;

endmodule

// File: rtl/sfifo_skid2.sv
// Two-entry in-order skid buffer; entry 0 is always the head.
module sfifo_skid2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       occ_o,
    output logic [WIDTH-1:0] head_o
);
    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]       occ_q, occ_d;

    // Next-state for entries and occupancy; clear wins over push/pop
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        if (clear_i) begin
            occ_d = 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push_i) begin
                        e0_d  = push_data_i;
                        occ_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        e0_d = push_data_i;
                    end else if (pop_i) begin
                        occ_d = 2'd0;
                    end else if (push_i) begin
                        e1_d  = push_data_i;
                        occ_d = 2'd2;
                    end
                end
                2'd2: begin
                    // A push while full is only legal alongside a pop
                    if (pop_i) begin
                        e0_d = e1_q;
                        if (push_i) e1_d = push_data_i;
                        else        occ_d = 2'd1;
                    end
                end
                default: occ_d = 2'd0;
            endcase
        end
    end

    // Entry and occupancy registers
    always_ff @(posedge clock) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = e0_q;

endmodule

// File: rtl/sfifo_reader.sv
// Pulls words out of an sfifo and presents them as a valid/ready stream.
module sfifo_reader
    import sfifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = sfifo_pkg::FIFO_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 flush,
    sfifo_reader_if.master       bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_sent
);
    rd_state_e             state_q, state_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  words_q;
    logic [1:0]            occ;
    logic [FIFO_WIDTH-1:0] head;
    logic                  pop, rd_issue, push, clear;
    logic [2:0]            need;

    // Next state, read issue and stream outputs
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (flush)       state_d = StFlush;
                else if (enable) state_d = StRun;
            end
            StRun: begin
                if (flush)        state_d = StFlush;
                else if (!enable) state_d = StIdle;
            end
            StFlush: begin
                if (bus.fifo_empty && !inflight_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        bus.m_valid = (occ != 2'd0) && (state_q != StFlush);
        pop         = bus.m_valid && bus.m_ready;
        // Slots that would be taken after this cycle if no new read goes out
        need        = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
        rd_issue    = !reset && !bus.fifo_empty &&
                      ((state_q == StRun && enable && need < 3'd2) || state_q == StFlush);
        // Entering FLUSH empties the buffer and drops the word arriving now
        clear       = (state_d == StFlush) && (state_q != StFlush);
        push        = inflight_q && (state_q != StFlush) && (state_d != StFlush);

        bus.fifo_read_n = !rd_issue;
        bus.m_data      = head;
        busy            = (state_q != StIdle) || (occ != 2'd0) || inflight_q;
    end

    // State, in-flight flag and handshake counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            inflight_q <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_issue;
            words_q    <= words_q + CNT_WIDTH'(pop);
        end
    end

    assign words_sent = words_q;

    sfifo_skid2 #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i (bus.fifo_data),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (head)
    );

endmodule
